// File: rtl/spram_init_ctrl.sv
// Front-end controller for an external single-port RAM: optional power-up fill, then one request per cycle.
// Build macro SPRAM_INIT_CTRL_INIT_EN enables the INIT fill state; without it the FSM comes out of reset in RUN.
module spram_init_ctrl #(
    parameter int unsigned            ADDR_WIDTH = 10,
    parameter int unsigned            DATA_WIDTH = 8,
    parameter logic [DATA_WIDTH-1:0]  INIT_VALUE = '0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_data,
    input  logic [DATA_WIDTH-1:0] ram_out
);

`ifdef SPRAM_INIT_CTRL_INIT_EN
    typedef enum logic {INIT, RUN} state_t;
    localparam state_t RESET_STATE = INIT;
    logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;
`else
    typedef enum logic {RUN} state_t;
    localparam state_t RESET_STATE = RUN;
    logic unused_init_value;
    assign unused_init_value = ^INIT_VALUE;
`endif

    state_t                state_q, state_d;
    logic                  ram_we_q, ram_we_d;
    logic [ADDR_WIDTH-1:0] ram_addr_q, ram_addr_d;
    logic [DATA_WIDTH-1:0] ram_data_q, ram_data_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rd_pend_q, rd_pend_d;
    logic                  init_done_q, init_done_d;

    always_comb begin
        state_d     = state_q;
        ram_we_d    = 1'b0;
        ram_addr_d  = ram_addr_q;
        ram_data_d  = ram_data_q;
        init_done_d = init_done_q;
        // bit0: read on the RAM pins, bit1: RAM output valid for capture next edge
        rd_pend_d   = {rd_pend_q[0], 1'b0};
        rsp_valid_d = rd_pend_q[1];
        rsp_rdata_d = rd_pend_q[1] ? ram_out : rsp_rdata_q;
        req_ready   = (state_q == RUN) && init_done_q;
`ifdef SPRAM_INIT_CTRL_INIT_EN
        cnt_d       = cnt_q;
`endif
        case (state_q)
`ifdef SPRAM_INIT_CTRL_INIT_EN
            INIT: begin
                // Leave once the all-ones address has been on the pins for a cycle.
                if (ram_we_q && (ram_addr_q == '1)) begin
                    state_d     = RUN;
                    init_done_d = 1'b1;
                end else begin
                    ram_we_d   = 1'b1;
                    ram_addr_d = cnt_q;
                    ram_data_d = INIT_VALUE;
                    cnt_d      = cnt_q + 1'b1;
                end
            end
`endif
            RUN: begin
                init_done_d = 1'b1;
                if (req_valid && req_ready) begin
                    ram_we_d     = req_we;
                    ram_addr_d   = req_addr;
                    ram_data_d   = req_wdata;
                    rd_pend_d[0] = ~req_we;
                end
            end
            default: state_d = RESET_STATE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= RESET_STATE;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_data_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rd_pend_q   <= '0;
            init_done_q <= 1'b0;
`ifdef SPRAM_INIT_CTRL_INIT_EN
            cnt_q       <= '0;
`endif
        end else begin
            state_q     <= state_d;
            ram_we_q    <= ram_we_d;
            ram_addr_q  <= ram_addr_d;
            ram_data_q  <= ram_data_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rd_pend_q   <= rd_pend_d;
            init_done_q <= init_done_d;
`ifdef SPRAM_INIT_CTRL_INIT_EN
            cnt_q       <= cnt_d;
`endif
        end
    end

    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_data  = ram_data_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign init_done = init_done_q;

endmodule

// File: doc/spram_init_ctrl.md
SPRAM_INIT_CTRL -- requirements
Module: spram_init_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, word address width of the downstream single-port RAM.
REQ-002 Parameter DATA_WIDTH, default 8, data width of the downstream single-port RAM.
REQ-003 Parameter INIT_VALUE, default 0, DATA_WIDTH-wide word written to every RAM location during initialisation.
REQ-004 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-005 Port: reset  input  1  synchronous, active-high reset.
REQ-006 Port: req_valid  input  1  user request present.
REQ-007 Port: req_ready  output  1  request accepted on a clk edge where req_valid && req_ready.
REQ-008 Port: req_we  input  1  1 = write request, 0 = read request.
REQ-009 Port: req_addr  input  ADDR_WIDTH  request word address.
REQ-010 Port: req_wdata  input  DATA_WIDTH  write data.
REQ-011 Port: rsp_valid  output  1  one-cycle pulse, rsp_rdata holds read result.
REQ-012 Port: rsp_rdata  output  DATA_WIDTH  registered read data.
REQ-013 Port: init_done  output  1  RAM initialisation complete.
REQ-014 Port: ram_we, ram_addr, ram_data  output  1/ADDR_WIDTH/DATA_WIDTH  registered drive to RAM clk/we/addr/data pins.
REQ-015 Port: ram_out  input  DATA_WIDTH  RAM registered read output.

Function
REQ-016 The FSM SHALL have two states: INIT and RUN.
REQ-017 In INIT, ram_we SHALL be 1, ram_data = INIT_VALUE, ram_addr SHALL increment by 1 per cycle from 0 to 2^ADDR_WIDTH-1; req_ready SHALL be 0.
REQ-018 After the cycle driving address 2^ADDR_WIDTH-1, the FSM SHALL enter RUN and init_done SHALL rise the same edge; INIT lasts exactly 2^ADDR_WIDTH cycles.
REQ-019 In RUN, req_ready SHALL be 1 every cycle (one operation per cycle, no backpressure).
REQ-020 On an accepted request, ram_we/ram_addr/ram_data SHALL be registered from req_we/req_addr/req_wdata at that edge; with no accepted request, ram_we SHALL be registered 0 and ram_addr/ram_data hold.
REQ-021 Read latency: for a read accepted at edge E0, rsp_valid SHALL be 1 and rsp_rdata = ram_out in the cycle following edge E2 (capture at E2), for exactly one cycle.
REQ-022 Back-to-back reads SHALL produce back-to-back rsp_valid pulses in request order; a 2-deep read-pending shift register tracks in-flight reads.
REQ-023 Writes SHALL never produce rsp_valid; rsp_rdata SHALL hold its last value when rsp_valid = 0.
REQ-024 A read to address A accepted the cycle after a write to A SHALL return the newly written data (RAM order guarantees this; no forwarding logic).
REQ-025 ram_addr counter in INIT SHALL wrap-check at all-ones without overflow into RUN addressing.

Reset
REQ-026 With reset = 1 at a clk edge: state <= INIT (or RUN per REQ-030), init counter <= 0, ram_we <= 0, ram_addr <= 0, ram_data <= 0, rsp_valid <= 0, rsp_rdata <= 0, read-pending bits <= 0, init_done <= 0.
REQ-027 Reset asserted mid-INIT SHALL restart initialisation from address 0; reset mid-RUN SHALL discard in-flight reads (no rsp_valid).
REQ-028 First INIT write (ram_we = 1, ram_addr = 0) SHALL be driven in the cycle after the edge that sees reset = 0.

Configuration
REQ-029 Macro SPRAM_INIT_CTRL_INIT_EN defined: INIT state present, behaviour per REQ-017/018.
REQ-030 Macro undefined: INIT state omitted, FSM leaves reset directly in RUN, init_done = 1 and req_ready = 1 from the first edge after reset deasserts, RAM contents undefined.

Verification
REQ-031 ADDR_WIDTH=4, INIT_EN defined, INIT_VALUE=8'hA5: release reset -> 16 cycles ram_we=1, addresses 0..15, then init_done=1; read all 16 addresses -> rsp_rdata=8'hA5 each.
REQ-032 Write 8'h3C to addr 5, next cycle read addr 5 -> rsp_valid exactly 2 cycles after read accept edge, rsp_rdata=8'h3C.
REQ-033 Reads to addrs 1,2,3 in consecutive cycles after writing 8'h11,8'h22,8'h33 -> three consecutive rsp_valid pulses returning 8'h11,8'h22,8'h33.
REQ-034 Assert reset at INIT address 7 -> restart at address 0, init_done low until 16 full INIT cycles complete; reset one cycle after read accept -> no rsp_valid.
REQ-035 INIT_EN undefined -> init_done=1 and req_ready=1 first cycle after reset release; write/read 8'hF0 at addr 0 returns 8'hF0.
